// File: rtl/posit_mult_scheduler.sv
// -----------------------------------------------------------------------------
// posit_mult_scheduler
//
// Shares one fixed-latency pipelined N-bit posit multiplier among NREQ
// requesters. A round-robin arbiter issues at most one operand pair per cycle.
// A tag pipeline follows each issued op through the multiplier, and its product
// is returned with the requester id through a result FIFO with backpressure.
// A credit counter (in-flight ops + FIFO occupancy) keeps the FIFO from
// overflowing.
//
// Optional feature macro: PMS_PERF_CNT_EN adds the perf_issue / perf_stall
// saturating 32-bit counters. Without the macro those ports do not exist.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high
//   req_valid  [NREQ]      per-requester operand valid
//   req_ready  [NREQ]      one-hot accept (combinational from req_valid)
//   req_a/b    [NREQ*N]    operands, requester i at [i*N +: N]
//   mul_a/b    [N]         operands to the multiplier, 0 when nothing issues
//   mul_res    [N]         product, captured MULT_LAT edges after issue
//   res_valid              result FIFO non-empty
//   res_ready              consumer takes the head entry
//   res_data   [N]         head product
//   res_id     [clog2 NREQ] requester id of the head product
//   busy                   any op in flight or FIFO non-empty
//   perf_issue [32]        (PMS_PERF_CNT_EN) number of transfers
//   perf_stall [32]        (PMS_PERF_CNT_EN) cycles with a request but no transfer
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module posit_mult_scheduler #(
   parameter int NREQ       = 4,
   parameter int N          = 16,
   parameter int MULT_LAT   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*N-1:0]        req_a,
   input  logic [NREQ*N-1:0]        req_b,
   output logic [N-1:0]             mul_a,
   output logic [N-1:0]             mul_b,
   input  logic [N-1:0]             mul_res,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [N-1:0]             res_data,
   output logic [$clog2(NREQ)-1:0] res_id,
   output logic                     busy
`ifdef PMS_PERF_CNT_EN
   ,
   output logic [31:0]              perf_issue,
   output logic [31:0]              perf_stall
`endif
);

   localparam int IDW = $clog2(NREQ);
   localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = $clog2(FIFO_DEPTH + 1);

   logic [IDW-1:0]      ptr;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       fifo_cnt;
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [N-1:0]        fifo_data [FIFO_DEPTH];
   logic [IDW-1:0]      fifo_id   [FIFO_DEPTH];
   logic [MULT_LAT-1:0] tag_vld;
   logic [IDW-1:0]      tag_id    [MULT_LAT];

   logic                grant_found;
   logic [IDW-1:0]      grant_id;
   logic                credit_ok;
   logic                issue;
   logic                pop;
   logic                push;

   assign res_valid = (fifo_cnt != '0);
   assign res_data  = fifo_data[rd_ptr];
   assign res_id    = fifo_id[rd_ptr];
   assign busy      = (cnt != '0);
   assign pop       = res_valid & res_ready;
   assign push      = tag_vld[MULT_LAT-1];

   // A same-cycle pop frees a slot, so a full credit pool can still issue.
   assign credit_ok = (cnt < CW'(FIFO_DEPTH)) | pop;

   // First valid requester at or after ptr, wrapping modulo NREQ.
   always_comb begin
      int idx;
      grant_found = 1'b0;
      grant_id    = '0;
      idx         = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_id    = IDW'(idx);
         end
      end
   end

   // Reset gating keeps the request side quiet while reset is held.
   assign issue = grant_found & credit_ok & ~reset;

   always_comb begin
      req_ready = '0;
      mul_a     = '0;
      mul_b     = '0;
      if (issue) begin
         req_ready[grant_id] = 1'b1;
         mul_a               = req_a[grant_id*N +: N];
         mul_b               = req_b[grant_id*N +: N];
      end
   end

   // Control state: arbiter pointer, credits, tag valids, FIFO pointers.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr      <= '0;
         cnt      <= '0;
         tag_vld  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (issue)
            ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
         cnt        <= cnt + CW'(issue) - CW'(pop);
         tag_vld[0] <= issue;
         for (int i = 1; i < MULT_LAT; i++)
            tag_vld[i] <= tag_vld[i-1];
         if (push)
            wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      end
   end

   // Data path: tag ids and FIFO storage carry no reset; validity lives above.
   always_ff @(posedge clk) begin
      tag_id[0] <= grant_id;
      for (int i = 1; i < MULT_LAT; i++)
         tag_id[i] <= tag_id[i-1];
      if (push) begin
         fifo_data[wr_ptr] <= mul_res;
         fifo_id[wr_ptr]   <= tag_id[MULT_LAT-1];
      end
   end

`ifdef PMS_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_issue <= '0;
         perf_stall <= '0;
      end else begin
         if (issue && (perf_issue != '1))
            perf_issue <= perf_issue + 1'b1;
         if ((|req_valid) && !issue && (perf_stall != '1))
            perf_stall <= perf_stall + 1'b1;
      end
   end
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset)
         assert (!(push && !pop && (fifo_cnt == CW'(FIFO_DEPTH))))
            else $error("posit_mult_scheduler: push into full result FIFO");
   end
`endif

endmodule

// File: tb/tb_posit_mult_scheduler.sv
`timescale 1ns/1ps
module tb_posit_mult_scheduler;

   localparam int NREQ       = 4;
   localparam int N          = 16;
   localparam int MULT_LAT   = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int IDW        = $clog2(NREQ);

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*N-1:0]    req_a;
   logic [NREQ*N-1:0]    req_b;
   logic [N-1:0]         mul_a;
   logic [N-1:0]         mul_b;
   logic [N-1:0]         mul_res;
   logic                 res_valid;
   logic                 res_ready;
   logic [N-1:0]         res_data;
   logic [IDW-1:0]       res_id;
   logic                 busy;
`ifdef PMS_PERF_CNT_EN
   logic [31:0]          perf_issue;
   logic [31:0]          perf_stall;
`endif

   posit_mult_scheduler #(
      .NREQ(NREQ), .N(N), .MULT_LAT(MULT_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_id(res_id), .busy(busy)
`ifdef PMS_PERF_CNT_EN
      , .perf_issue(perf_issue), .perf_stall(perf_stall)
`endif
   );

   always #5 clk = ~clk;

   // Stub multiplier: product = a ^ b, delayed MULT_LAT edges.
   logic [N-1:0] mpipe [MULT_LAT];
   always @(posedge clk) begin
      mpipe[0] <= mul_a ^ mul_b;
      for (int i = 1; i < MULT_LAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mul_res = mpipe[MULT_LAT-1];

   // Reference model: every accepted op, in issue order, with the cycle at
   // which it becomes visible at the FIFO head side.
   typedef struct {
      int          id;
      logic [N-1:0] data;
      int          due;
   } ent_t;

   ent_t pend[$];
   int   grants[$];
   int   m_ptr   = 0;
   int   cyc     = 0;
   int   n_issue = 0;
   int   checks  = 0;
   int   errors  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rand_operands();
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*N +: N] = N'($urandom);
         req_b[i*N +: N] = N'($urandom);
      end
   endtask

   // One clock cycle: inputs were set after the previous falling edge.
   task automatic cycle();
      int            vis;
      int            g;
      bit            pop;
      bit            credit;
      logic [NREQ-1:0] exp_rdy;
      logic [N-1:0]  ea;
      logic [N-1:0]  eb;
      #1;
      vis = 0;
      foreach (pend[i]) if (pend[i].due <= cyc) vis++;
      pop    = (vis > 0) && res_ready;
      credit = (pend.size() < FIFO_DEPTH) || pop;
      g = -1;
      if (credit)
         for (int k = 0; k < NREQ; k++)
            if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      exp_rdy = '0;
      ea = '0;
      eb = '0;
      if (g >= 0) begin
         exp_rdy[g] = 1'b1;
         ea = req_a[g*N +: N];
         eb = req_b[g*N +: N];
      end
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("mul_a", 64'(mul_a), 64'(ea));
      chk("mul_b", 64'(mul_b), 64'(eb));
      chk("res_valid", 64'(res_valid), 64'(vis > 0));
      if (vis > 0) begin
         chk("res_data", 64'(res_data), 64'(pend[0].data));
         chk("res_id", 64'(res_id), 64'(pend[0].id));
      end
      chk("busy", 64'(busy), 64'(pend.size() > 0));
      @(posedge clk);
      if (pop) void'(pend.pop_front());
      if (g >= 0) begin
         pend.push_back('{id: g, data: ea ^ eb, due: cyc + 1 + MULT_LAT});
         grants.push_back(g);
         m_ptr = (g + 1) % NREQ;
         n_issue++;
      end
      cyc++;
      @(negedge clk);
   endtask

   // Synchronous reset for one edge, with every requester asking meanwhile.
   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '1;
      rand_operands();
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_mul_a", 64'(mul_a), 64'(0));
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_res_valid", 64'(res_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_req_ready_held", 64'(req_ready), 64'(0));
`ifdef PMS_PERF_CNT_EN
      chk("rst_perf_issue", 64'(perf_issue), 64'(0));
      chk("rst_perf_stall", 64'(perf_stall), 64'(0));
`endif
      reset     = 1'b0;
      req_valid = '0;
      pend.delete();
      m_ptr = 0;
      cyc++;
   endtask

   initial begin
      int first;
      int base;
      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      res_ready = 1'b0;
      @(negedge clk);
      do_reset();

      // Single op from requester 0
      req_valid = 4'b0001;
      req_a[15:0] = 16'h4000;
      req_b[15:0] = 16'h3000;
      res_ready = 1'b0;
      cycle();
      req_valid = '0;
      first = -1;
      for (int i = 1; i <= 8; i++) begin
         if (first < 0 && res_valid) first = i;
         cycle();
      end
      chk("t1_latency", 64'(first), 64'(5));
      chk("t1_data", 64'(res_data), 64'(16'h7000));
      chk("t1_id", 64'(res_id), 64'(0));
      res_ready = 1'b1;
      cycle();
      chk("t1_drained", 64'(res_valid), 64'(0));

      // All requesters valid, consumer always ready: round-robin order
      do_reset();
      grants.delete();
      res_ready = 1'b1;
      for (int i = 0; i < 24; i++) begin
         req_valid = '1;
         rand_operands();
         cycle();
      end
      chk("t2_count", 64'(grants.size() >= 8), 64'(1));
      for (int i = 0; i < 8 && i < grants.size(); i++)
         chk("t2_grant_order", 64'(grants[i]), 64'(i % NREQ));
      req_valid = '0;
      for (int i = 0; i < 10; i++) cycle();

      // Consumer stalled: credit caps transfers at FIFO_DEPTH
      do_reset();
      res_ready = 1'b0;
      base = n_issue;
      for (int i = 0; i < 10; i++) begin
         req_valid = '1;
         rand_operands();
         cycle();
      end
      chk("t3_credit_cap", 64'(n_issue - base), 64'(FIFO_DEPTH));
      base = n_issue;
      res_ready = 1'b1;
      cycle();
      chk("t3_pop_and_issue", 64'(n_issue - base), 64'(1));
      res_ready = 1'b0;
      for (int i = 0; i < 6; i++) cycle();
      chk("t3_one_new_issue", 64'(n_issue - base), 64'(1));
      req_valid = '0;
      res_ready = 1'b1;
      for (int i = 0; i < 12; i++) cycle();

      // Random traffic with random backpressure, 100 ops
      base = n_issue;
      for (int c = 0; c < 3000 && (n_issue - base) < 100; c++) begin
         req_valid = NREQ'($urandom);
         rand_operands();
         res_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      chk("t4_ops_done", 64'((n_issue - base) >= 100), 64'(1));
      req_valid = '0;
      res_ready = 1'b1;
      for (int i = 0; i < 20; i++) cycle();
      chk("t4_drain_busy", 64'(busy), 64'(0));

      // Reset with results in the FIFO and ops in flight
      do_reset();
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_valid = '1;
         rand_operands();
         cycle();
      end
      req_valid = '0;
      for (int i = 0; i < 3; i++) cycle();
      chk("t5_pre_fifo_valid", 64'(res_valid), 64'(1));
      do_reset();
      res_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t5_no_stale", 64'(res_valid), 64'(0));
         cycle();
      end

`ifdef PMS_PERF_CNT_EN
      // 4 issues + 3 stalls, drain, then 6 spaced single issues
      do_reset();
      res_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         req_valid = '1;
         rand_operands();
         cycle();
      end
      req_valid = '0;
      res_ready = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      for (int i = 0; i < 12; i++) begin
         req_valid = (i % 2 == 0) ? 4'b0010 : 4'b0000;
         rand_operands();
         cycle();
      end
      req_valid = '0;
      chk("t6_perf_issue", 64'(perf_issue), 64'(10));
      chk("t6_perf_stall", 64'(perf_stall), 64'(3));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
